// File: rtl/reg_pipe.sv
// reg_pipe: elastic pipeline register, Depth stages of Width bits with
// valid/ready handshake, bubble collapsing, sync flush and occupancy count.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           clears all stage valids next cycle, blocks both sides now
//   in_valid/ready  upstream handshake, in_data payload
//   out_valid/ready downstream handshake, out_data from the last stage
//   count           registered number of valid stages (0..Depth)
//
// Build option: define CLEAR_DATA_EN to also reset the data registers to 0.
// Without it only the control state (valids, count) is reset.

module reg_pipe #(
  parameter  int Width = 8,
  parameter  int Depth = 3,
  localparam int CntW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic [CntW-1:0]  count
);

  logic [Depth-1:0] vld_q, vld_d;
  logic [Width-1:0] dat_q [Depth];
  logic [Width-1:0] dat_d [Depth];
  logic [CntW-1:0]  count_q, count_d;

  logic [Depth-1:0] rdy;
  logic             in_fire;
  logic             out_fire;

  // Ready chain: a stage accepts if it is empty or everything
  // downstream of it will move this cycle.
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int i = Depth - 1; i >= 0; i--) begin
      acc    = ~vld_q[i] | acc;
      rdy[i] = acc;
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = vld_q[Depth-1] & ~flush;
  assign out_data  = dat_q[Depth-1];
  assign count     = count_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;

    if (rdy[0]) begin
      vld_d[0] = in_valid;
      if (in_valid && !flush) begin
        dat_d[0] = in_data;
      end
    end

    for (int i = 1; i < Depth; i++) begin
      if (rdy[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1] && !flush) begin
          dat_d[i] = dat_q[i-1];
        end
      end
    end

    if (flush) begin
      vld_d = '0;
    end
  end

  always_comb begin
    count_d = count_q
            + CntW'(in_fire)
            - CntW'(out_fire);
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

`ifdef CLEAR_DATA_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      dat_q <= dat_d;
    end
  end
`else
  // Payload has no reset; valids qualify it.
  always_ff @(posedge clk) begin
    dat_q <= dat_d;
  end
`endif

endmodule
